fp32_to_int_pipe: RTL

Pipelined, parametrised IEEE‑754 single‑precision to integer converter. It supports signed and unsigned results of configurable width, selectable rounding, saturation and exception flags. It sits on the datapath between float‑producing blocks and integer consumers, with valid/ready handshakes on both sides. Throughput is one conversion per cycle, with full backpressure support.

---
 rtl/fp32_to_int_pipe.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/fp32_to_int_pipe.sv
// Three-stage IEEE-754 binary32 to INT_W-bit integer converter with valid/ready flow control.
// Define FP2INT_RNE_EN to enable round-to-nearest-even via in_rnd; otherwise all conversions truncate.
module fp32_to_int_pipe #(
    parameter int unsigned INT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_signed,
    input  logic             in_rnd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INT_W-1:0] out_data,
    output logic             out_invalid,
    output logic             out_inexact
);

    localparam int unsigned MAG_W = INT_W + 1;
    localparam logic [INT_W-1:0] SMAX = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic [INT_W-1:0] SMIN = {1'b1, {(INT_W-1){1'b0}}};
    localparam logic [INT_W-1:0] UMAX = {INT_W{1'b1}};

    // Each stage may load when empty or when its contents move on this cycle.
    logic s1_valid, s2_valid;
    logic s1_load, s2_load, s3_load;

    assign s3_load  = !out_valid || out_ready;
    assign s2_load  = !s2_valid || s3_load;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    // S1: classify and unpack
    logic              s1_neg, s1_signed, s1_zero, s1_den, s1_inf, s1_nan;
    logic [23:0]       s1_mant;
    logic signed [9:0] s1_e;
`ifdef FP2INT_RNE_EN
    logic              s1_rnd;
`else
    logic              unused_rnd;
    assign unused_rnd = in_rnd;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_neg    <= 1'b0;
            s1_signed <= 1'b0;
            s1_zero   <= 1'b0;
            s1_den    <= 1'b0;
            s1_inf    <= 1'b0;
            s1_nan    <= 1'b0;
            s1_mant   <= '0;
            s1_e      <= '0;
`ifdef FP2INT_RNE_EN
            s1_rnd    <= 1'b0;
`endif
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_neg    <= in_data[31];
                s1_signed <= in_signed;
                s1_zero   <= (in_data[30:23] == 8'd0) && (in_data[22:0] == 23'd0);
                s1_den    <= (in_data[30:23] == 8'd0) && (in_data[22:0] != 23'd0);
                s1_inf    <= (in_data[30:23] == 8'hFF) && (in_data[22:0] == 23'd0);
                s1_nan    <= (in_data[30:23] == 8'hFF) && (in_data[22:0] != 23'd0);
                s1_mant   <= {(in_data[30:23] != 8'd0), in_data[22:0]};
                s1_e      <= $signed({2'b00, in_data[30:23]}) - 10'sd127;
`ifdef FP2INT_RNE_EN
                s1_rnd    <= in_rnd;
`endif
            end
        end
    end

    // S2: align magnitude, collect guard/sticky, optional round increment
    logic [MAG_W-1:0] al_mag;
    logic             al_g, al_s, al_ovf;
    logic [47:0]      rsh;
    logic [6:0]       lsh;
    logic [4:0]       rsa;
    logic [MAG_W:0]   rnd_sum;

    always_comb begin
        al_mag = '0;
        al_g   = 1'b0;
        al_s   = 1'b0;
        al_ovf = 1'b0;
        rsh    = '0;
        lsh    = '0;
        rsa    = '0;
        if (s1_den) begin
            al_s = 1'b1;
        end else if (!s1_zero && !s1_inf && !s1_nan) begin
            // Leading one sits at bit e, so anything above bit INT_W cannot fit.
            al_ovf = s1_e > $signed(10'(INT_W));
            if (s1_e >= 10'sd23) begin
                lsh    = 7'(s1_e - 10'sd23);
                al_mag = MAG_W'(s1_mant) << lsh;
            end else if (s1_e >= 10'sd0) begin
                rsa    = 5'(10'sd23 - s1_e);
                rsh    = {s1_mant, 24'd0} >> rsa;
                al_mag = MAG_W'(rsh[47:24]);
                al_g   = rsh[23];
                al_s   = |rsh[22:0];
            end else begin
                al_g = (s1_e == -10'sd1);
                al_s = al_g ? (|s1_mant[22:0]) : 1'b1;
            end
        end
    end

`ifdef FP2INT_RNE_EN
    logic rnd_inc;
    assign rnd_inc = s1_rnd && al_g && (al_s || al_mag[0]);
    assign rnd_sum = {1'b0, al_mag} + (MAG_W+1)'(rnd_inc);
`else
    assign rnd_sum = {1'b0, al_mag};
`endif

    logic [MAG_W-1:0] s2_mag;
    logic             s2_ovf, s2_inx, s2_nan, s2_inf, s2_neg, s2_signed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid  <= 1'b0;
            s2_mag    <= '0;
            s2_ovf    <= 1'b0;
            s2_inx    <= 1'b0;
            s2_nan    <= 1'b0;
            s2_inf    <= 1'b0;
            s2_neg    <= 1'b0;
            s2_signed <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_mag    <= rnd_sum[MAG_W-1:0];
                s2_ovf    <= al_ovf || rnd_sum[MAG_W];
                s2_inx    <= al_g || al_s;
                s2_nan    <= s1_nan;
                s2_inf    <= s1_inf;
                s2_neg    <= s1_neg;
                s2_signed <= s1_signed;
            end
        end
    end

    // S3: sign, range check, saturation and flags
    logic [INT_W-1:0] neg_mag, res;
    logic             res_inv, res_inx;

    assign neg_mag = '0 - s2_mag[INT_W-1:0];

    always_comb begin
        res     = '0;
        res_inv = 1'b0;
        if (s2_nan) begin
            res_inv = 1'b1;
            res     = s2_signed ? SMAX : UMAX;
        end else if (s2_inf) begin
            res_inv = 1'b1;
            if (s2_neg) res = s2_signed ? SMIN : '0;
            else        res = s2_signed ? SMAX : UMAX;
        end else if (s2_signed) begin
            if (!s2_neg) begin
                if (s2_ovf || s2_mag[INT_W] || s2_mag[INT_W-1]) begin
                    res_inv = 1'b1;
                    res     = SMAX;
                end else begin
                    res = s2_mag[INT_W-1:0];
                end
            end else if (s2_ovf || s2_mag[INT_W] || (s2_mag[INT_W-1] && (|s2_mag[INT_W-2:0]))) begin
                res_inv = 1'b1;
                res     = SMIN;
            end else begin
                res = neg_mag;
            end
        end else if (!s2_neg) begin
            if (s2_ovf || s2_mag[INT_W]) begin
                res_inv = 1'b1;
                res     = UMAX;
            end else begin
                res = s2_mag[INT_W-1:0];
            end
        end else begin
            res_inv = s2_ovf || (|s2_mag);
        end
        res_inx = s2_inx && !res_inv;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_invalid <= 1'b0;
            out_inexact <= 1'b0;
        end else if (s3_load) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_data    <= res;
                out_invalid <= res_inv;
                out_inexact <= res_inx;
            end
        end
    end

endmodule
